// File: rtl/fsm_updown_counter_param.sv
// Parametrised Moore up/down counter with wrap/saturate boundary mode, synchronous
// load, terminal-count flags, a boundary-event pulse and a registered direction state.
module fsm_updown_counter_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int STEP   = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       X,
  input  logic             Sat,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Cuenta,
  output logic [1:0]       Dir,
  output logic             Max,
  output logic             Min,
  output logic             Wrap
);

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DOWN = 2'b10;

  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);
  // Truncates to 0 when MODULO == 2^WIDTH, which is still correct modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] MOD_C  = WIDTH'(MODULO);

  logic [WIDTH-1:0] cuenta_q, cuenta_d;
  logic [1:0]       dir_q, dir_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   c_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   sum_up;

  always_comb begin
    c_ext    = {1'b0, cuenta_q};
    d_ext    = {1'b0, D};
    sum_up   = c_ext + STEP_W;
    cuenta_d = cuenta_q;
    dir_d    = dir_q;
    wrap_d   = 1'b0;
    if (Load) begin
      cuenta_d = (d_ext <= MAX_W) ? D : MAX_C;
      dir_d    = HOLD;
    end else if (En) begin
      case (X)
        UP: begin
          dir_d = UP;
          if (sum_up <= MAX_W) begin
            cuenta_d = sum_up[WIDTH-1:0];
          end else if (!Sat) begin
            cuenta_d = cuenta_q + STEP_C - MOD_C;
            wrap_d   = 1'b1;
          end else begin
            cuenta_d = MAX_C;
            wrap_d   = (cuenta_q != MAX_C);
          end
        end
        DOWN: begin
          dir_d = DOWN;
          if (c_ext >= STEP_W) begin
            cuenta_d = cuenta_q - STEP_C;
          end else if (!Sat) begin
            cuenta_d = cuenta_q + MOD_C - STEP_C;
            wrap_d   = 1'b1;
          end else begin
            cuenta_d = '0;
            wrap_d   = (cuenta_q != '0);
          end
        end
        default: dir_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cuenta_q <= '0;
      dir_q    <= HOLD;
      wrap_q   <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      dir_q    <= dir_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Cuenta = cuenta_q;
  assign Dir    = dir_q;
  assign Wrap   = wrap_q;
  assign Max    = (cuenta_q == MAX_C);
  assign Min    = (cuenta_q == '0);

endmodule

// File: tb/tb_fsm_updown_counter_param.sv
// Directed bench for fsm_updown_counter_param: three instances (MOD10/STEP1,
// MOD10/STEP3, MOD16/STEP1) driven from a vector table and short sequences.
module tb_fsm_updown_counter_param;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  // Instance A: MODULO=10, STEP=1
  logic       a_en = 0, a_sat = 0, a_load = 0, a_wrap, a_max, a_min;
  logic [1:0] a_x = 0, a_dir;
  logic [3:0] a_d = 0, a_cnt;
  // Instance B: MODULO=10, STEP=3
  logic       b_en = 0, b_sat = 0, b_load = 0, b_wrap, b_max, b_min;
  logic [1:0] b_x = 0, b_dir;
  logic [3:0] b_d = 0, b_cnt;
  // Instance C: MODULO=16, STEP=1
  logic       c_en = 0, c_sat = 0, c_load = 0, c_wrap, c_max, c_min;
  logic [1:0] c_x = 0, c_dir;
  logic [3:0] c_d = 0, c_cnt;

  fsm_updown_counter_param #(.WIDTH(4), .MODULO(10), .STEP(1)) u_a (
    .Clk(Clk), .Rst(Rst), .En(a_en), .X(a_x), .Sat(a_sat), .Load(a_load), .D(a_d),
    .Cuenta(a_cnt), .Dir(a_dir), .Max(a_max), .Min(a_min), .Wrap(a_wrap));
  fsm_updown_counter_param #(.WIDTH(4), .MODULO(10), .STEP(3)) u_b (
    .Clk(Clk), .Rst(Rst), .En(b_en), .X(b_x), .Sat(b_sat), .Load(b_load), .D(b_d),
    .Cuenta(b_cnt), .Dir(b_dir), .Max(b_max), .Min(b_min), .Wrap(b_wrap));
  fsm_updown_counter_param #(.WIDTH(4), .MODULO(16), .STEP(1)) u_c (
    .Clk(Clk), .Rst(Rst), .En(c_en), .X(c_x), .Sat(c_sat), .Load(c_load), .D(c_d),
    .Cuenta(c_cnt), .Dir(c_dir), .Max(c_max), .Min(c_min), .Wrap(c_wrap));

  typedef struct {
    logic       load;
    logic       en;
    logic [1:0] x;
    logic       sat;
    logic [3:0] d;
    logic [3:0] cnt;
    logic [1:0] dir;
    logic       wrap;
    logic       max;
    logic       min;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Packed observation: {cnt[3:0], dir[1:0], wrap, max, min}
  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got cnt=%0d dir=%b wrap=%b max=%b min=%b, want cnt=%0d dir=%b wrap=%b max=%b min=%b",
               name, got[8:5], got[4:3], got[2], got[1], got[0],
               exp[8:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [8:0] pk(input logic [3:0] cnt, input logic [1:0] dir,
                                    input logic wrap, input logic max, input logic min);
    return {cnt, dir, wrap, max, min};
  endfunction

  vec_t tbl [21];

  initial begin
    // Instance B (MODULO=10, STEP=3); each row is the state after one edge.
    //           load en  x      sat d      cnt    dir    wr  mx  mn
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 4'd1,  4'd1, 2'b00, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'd0,  4'd8, 2'b10, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'd0,  4'd5, 2'b10, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'd0,  4'd2, 2'b10, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 2'b10, 1'b0, 4'd0,  4'd9, 2'b10, 1, 1, 0};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 1'b0, 4'd8,  4'd8, 2'b00, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 2'b01, 1'b1, 4'd0,  4'd9, 2'b01, 1, 1, 0};
    tbl[7]  = '{1'b0, 1'b1, 2'b01, 1'b1, 4'd0,  4'd9, 2'b01, 0, 1, 0};
    tbl[8]  = '{1'b1, 1'b0, 2'b00, 1'b0, 4'd1,  4'd1, 2'b00, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 2'b10, 1'b1, 4'd0,  4'd0, 2'b10, 1, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 2'b10, 1'b1, 4'd0,  4'd0, 2'b10, 0, 0, 1};
    tbl[11] = '{1'b0, 1'b1, 2'b11, 1'b0, 4'd0,  4'd0, 2'b00, 0, 0, 1};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 1'b0, 4'd4,  4'd4, 2'b00, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'd0,  4'd7, 2'b01, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 2'b01, 1'b0, 4'd0,  4'd7, 2'b01, 0, 0, 0};
    tbl[15] = '{1'b0, 1'b1, 2'b00, 1'b0, 4'd0,  4'd7, 2'b00, 0, 0, 0};
    tbl[16] = '{1'b1, 1'b1, 2'b01, 1'b0, 4'd15, 4'd9, 2'b00, 0, 1, 0};
    tbl[17] = '{1'b0, 1'b1, 2'b01, 1'b0, 4'd0,  4'd2, 2'b01, 1, 0, 0};
    tbl[18] = '{1'b0, 1'b1, 2'b01, 1'b1, 4'd0,  4'd5, 2'b01, 0, 0, 0};
    tbl[19] = '{1'b1, 1'b1, 2'b10, 1'b1, 4'd9,  4'd9, 2'b00, 0, 1, 0};
    tbl[20] = '{1'b0, 1'b1, 2'b10, 1'b1, 4'd0,  4'd6, 2'b10, 0, 0, 0};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("reset_a", pk(a_cnt, a_dir, a_wrap, a_max, a_min), pk(4'd0, 2'b00, 0, 0, 1));
    check("reset_b", pk(b_cnt, b_dir, b_wrap, b_max, b_min), pk(4'd0, 2'b00, 0, 0, 1));
    check("reset_c", pk(c_cnt, c_dir, c_wrap, c_max, c_min), pk(4'd0, 2'b00, 0, 0, 1));

    // A: count up from reset, wrap at 9 -> 0, continue to 6.
    a_en = 1'b1; a_x = 2'b01; a_sat = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] e;
      e = 4'(i % 10);
      tick();
      check($sformatf("a_up_%0d", i), pk(a_cnt, a_dir, a_wrap, a_max, a_min),
            pk(e, 2'b01, e == 0, e == 9, e == 0));
    end

    // A: asynchronous reset between edges while counting at 6.
    #3 Rst = 1'b0;
    #1;
    check("a_async_rst", pk(a_cnt, a_dir, a_wrap, a_max, a_min), pk(4'd0, 2'b00, 0, 0, 1));
    #2 Rst = 1'b1;
    tick();
    check("a_resume", pk(a_cnt, a_dir, a_wrap, a_max, a_min), pk(4'd1, 2'b01, 0, 0, 0));
    a_en = 1'b0; a_x = 2'b00;

    // B: table-driven vectors.
    for (int i = 0; i < 21; i++) begin
      b_load = tbl[i].load; b_en = tbl[i].en; b_x = tbl[i].x;
      b_sat = tbl[i].sat;   b_d = tbl[i].d;
      tick();
      check($sformatf("b_vec_%0d", i), pk(b_cnt, b_dir, b_wrap, b_max, b_min),
            pk(tbl[i].cnt, tbl[i].dir, tbl[i].wrap, tbl[i].max, tbl[i].min));
    end
    b_load = 1'b0; b_en = 1'b0; b_x = 2'b00;

    // C: full-range wrap 15 -> 0.
    c_load = 1'b1; c_d = 4'd13;
    tick();
    check("c_load13", pk(c_cnt, c_dir, c_wrap, c_max, c_min), pk(4'd13, 2'b00, 0, 0, 0));
    c_load = 1'b0; c_en = 1'b1; c_x = 2'b01;
    tick();
    check("c_14", pk(c_cnt, c_dir, c_wrap, c_max, c_min), pk(4'd14, 2'b01, 0, 0, 0));
    tick();
    check("c_15", pk(c_cnt, c_dir, c_wrap, c_max, c_min), pk(4'd15, 2'b01, 0, 1, 0));
    tick();
    check("c_wrap0", pk(c_cnt, c_dir, c_wrap, c_max, c_min), pk(4'd0, 2'b01, 1, 0, 1));
    tick();
    check("c_1", pk(c_cnt, c_dir, c_wrap, c_max, c_min), pk(4'd1, 2'b01, 0, 0, 0));
    c_en = 1'b0; c_x = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
